// File: rtl/bomberman_pkg.sv
// Shared types and palette constants for the bomberman overlay layers.
package bomberman_pkg;

  localparam logic [7:0] TRANSPARENT = 8'd137;
  localparam logic [7:0] BOMB_IDX    = 8'd20;
  localparam logic [7:0] FLAME_IDX0  = 8'd16;

  typedef enum logic [1:0] {IDLE, ARMED, BLAST} bomb_state_t;

  typedef logic [3:0] cell_t;

  // Unsigned distance between two cells; never wraps through zero.
  function automatic cell_t cell_dist(cell_t a, cell_t b);
    return (a >= b) ? cell_t'(a - b) : cell_t'(b - a);
  endfunction

endpackage

// File: rtl/pix2cell.sv
// Combinational pixel-to-cell mapping shared by the overlay layers.
// Pixels left of / above the grid origin are rejected before the
// subtraction result is used, so no wrap-around can alias into the grid.
module pix2cell
  import bomberman_pkg::*;
#(
  parameter int          CELL_LOG2 = 5,
  parameter logic [9:0]  GRID_X0   = 10'd64,
  parameter logic [9:0]  GRID_Y0   = 10'd32,
  parameter int          GRID_W    = 15,
  parameter int          GRID_H    = 13
) (
  input  logic [9:0] spotX,
  input  logic [9:0] spotY,
  output logic       in_grid,
  output cell_t      cx,
  output cell_t      cy
);

  logic [9:0] px, py, colf, rowf;

  assign px   = spotX - GRID_X0;
  assign py   = spotY - GRID_Y0;
  assign colf = px >> CELL_LOG2;
  assign rowf = py >> CELL_LOG2;

  assign in_grid = (spotX >= GRID_X0) && (spotY >= GRID_Y0) &&
                   (int'(colf) < GRID_W) && (int'(rowf) < GRID_H);
  assign cx = colf[3:0];
  assign cy = rowf[3:0];

endmodule

// File: rtl/flame_layer.sv
// Bomb / flame overlay layer: one bomb at a time, frame-counted fuse,
// cross-shaped blast, registered palette output (1-cycle pixel latency).
// Optional build macro: FLAME_ANIM_EN cycles the flame through 4 palette
// entries, stepping every 4 frames of the blast.
module flame_layer
  import bomberman_pkg::*;
#(
  parameter int          CELL_LOG2    = 5,
  parameter logic [9:0]  GRID_X0      = 10'd64,
  parameter logic [9:0]  GRID_Y0      = 10'd32,
  parameter int          GRID_W       = 15,
  parameter int          GRID_H       = 13,
  parameter int          FUSE_FRAMES  = 120,
  parameter int          BLAST_FRAMES = 30,
  parameter int          RANGE        = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       new_frame,
  input  logic [9:0] spotX,
  input  logic [9:0] spotY,
  input  logic       drop,
  input  logic [3:0] drop_cx,
  input  logic [3:0] drop_cy,
  output logic [7:0] flame_color,
  output logic       busy,
  output logic       exploding
);

  bomb_state_t state;
  logic [7:0]  frame_cnt;
  cell_t       bx, by, cx, cy;
  logic        in_grid, drop_ok, flame_hit;
  logic [7:0]  flame_idx, color_d;

  pix2cell #(
    .CELL_LOG2(CELL_LOG2), .GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0),
    .GRID_W(GRID_W), .GRID_H(GRID_H)
  ) u_pix2cell (
    .spotX(spotX), .spotY(spotY), .in_grid(in_grid), .cx(cx), .cy(cy)
  );

  assign drop_ok = drop && (int'(drop_cx) < GRID_W) && (int'(drop_cy) < GRID_H);

  // Bomb lifecycle FSM; busy/exploding are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      bx        <= '0;
      by        <= '0;
      busy      <= 1'b0;
      exploding <= 1'b0;
    end else begin
      case (state)
        IDLE: if (drop_ok) begin
          bx        <= drop_cx;
          by        <= drop_cy;
          frame_cnt <= 8'(FUSE_FRAMES - 1);
          state     <= ARMED;
          busy      <= 1'b1;
        end
        ARMED: if (new_frame) begin
          if (frame_cnt == '0) begin
            frame_cnt <= 8'(BLAST_FRAMES - 1);
            state     <= BLAST;
            exploding <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt - 8'd1;
          end
        end
        BLAST: if (new_frame) begin
          if (frame_cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            exploding <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          exploding <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLAME_ANIM_EN
  logic [1:0] phase, sub;

  // Flame animation phase: steps every 4th frame of the blast, restarts per blast.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      sub   <= '0;
    end else if (state == ARMED && new_frame && frame_cnt == '0) begin
      phase <= '0;
      sub   <= '0;
    end else if (state == BLAST && new_frame) begin
      sub <= sub + 2'd1;
      if (sub == 2'd3) phase <= phase + 2'd1;
    end
  end

  assign flame_idx = FLAME_IDX0 + {6'd0, phase};
`else
  assign flame_idx = FLAME_IDX0;
`endif

  assign flame_hit = ((cy == by) && (int'(cell_dist(cx, bx)) <= RANGE)) ||
                     ((cx == bx) && (int'(cell_dist(cy, by)) <= RANGE));

  // Palette selection for the current pixel from the pre-edge state.
  always_comb begin
    color_d = TRANSPARENT;
    if (in_grid) begin
      case (state)
        ARMED: if (cx == bx && cy == by && !frame_cnt[3]) color_d = BOMB_IDX;
        BLAST: if (flame_hit) color_d = flame_idx;
        default: color_d = TRANSPARENT;
      endcase
    end
  end

  // Output register keeps this layer aligned with its sibling layers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flame_color <= TRANSPARENT;
    else          flame_color <= color_d;
  end

endmodule

// File: tb/tb_flame_layer.sv
// Self-checking bench for flame_layer: directed vector table plus
// randomized pixel probes compared against a frame-level behavioural model.
module tb_flame_layer;
  import bomberman_pkg::*;

  logic       clk = 1'b0, reset_n = 1'b0, new_frame = 1'b0, drop = 1'b0;
  logic [9:0] spotX = '0, spotY = '0;
  logic [3:0] drop_cx = '0, drop_cy = '0;
  logic [7:0] flame_color;
  logic       busy, exploding;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  flame_layer dut (
    .clk(clk), .reset_n(reset_n), .new_frame(new_frame),
    .spotX(spotX), .spotY(spotY), .drop(drop),
    .drop_cx(drop_cx), .drop_cy(drop_cy),
    .flame_color(flame_color), .busy(busy), .exploding(exploding)
  );

  // Model: frames of fuse left, frames of blast left, blast frames already seen.
  int fuse_left = 0, blast_left = 0, blast_seen = 0, mbx = 0, mby = 0;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int m_flame();
`ifdef FLAME_ANIM_EN
    return int'(FLAME_IDX0) + (blast_seen / 4) % 4;
`else
    return int'(FLAME_IDX0);
`endif
  endfunction

  function automatic int m_color(int sx, int sy);
    int cx, cy;
    if (sx < 64 || sx >= 64 + 15 * 32 || sy < 32 || sy >= 32 + 13 * 32) return 137;
    cx = (sx - 64) / 32;
    cy = (sy - 32) / 32;
    if (fuse_left > 0)
      return (cx == mbx && cy == mby && ((fuse_left - 1) / 8) % 2 == 0) ? int'(BOMB_IDX) : 137;
    if (blast_left > 0 &&
        ((cy == mby && iabs(cx - mbx) <= 2) || (cx == mbx && iabs(cy - mby) <= 2)))
      return m_flame();
    return 137;
  endfunction

  function automatic void m_update(bit nf, bit dr, int dcx, int dcy);
    if (fuse_left == 0 && blast_left == 0) begin
      if (dr && dcx < 15 && dcy < 13) begin
        fuse_left = 120; mbx = dcx; mby = dcy;
      end
    end else if (fuse_left > 0) begin
      if (nf) begin
        fuse_left--;
        if (fuse_left == 0) begin blast_left = 30; blast_seen = 0; end
      end
    end else if (nf) begin
      blast_left--; blast_seen++;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel-clock cycle: drive at negedge, check 1 ns after the rising edge.
  task automatic step(input bit nf, input bit dr, input int dcx, input int dcy,
                      input int sx, input int sy);
    int e;
    @(negedge clk);
    new_frame = nf; drop = dr;
    drop_cx = dcx[3:0]; drop_cy = dcy[3:0];
    spotX = sx[9:0]; spotY = sy[9:0];
    e = m_color(sx, sy);
    @(posedge clk); #1;
    m_update(nf, dr, dcx, dcy);
    chk("color", flame_color, e);
    chk("busy", busy, (fuse_left > 0 || blast_left > 0));
    chk("exploding", exploding, (blast_left > 0));
    new_frame = 1'b0; drop = 1'b0;
  endtask

  function automatic int near(int b, int org);
    int v;
    v = org + (b - 3 + int'($urandom_range(0, 6))) * 32 + int'($urandom_range(0, 31));
    if (v < 0) v += 1024;
    return v;
  endfunction

  // One short frame: the new_frame pulse, then bomb/off/bomb probes
  // (back-to-back so a wrong pipeline latency shows up) and a random nearby pixel.
  task automatic run_frame();
    int bpx, bpy;
    bpx = 64 + mbx * 32 + 5;
    bpy = 32 + mby * 32 + 5;
    step(1, 0, 0, 0, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
    step(0, 0, 0, 0, bpx, bpy);
    step(0, 0, 0, 0, bpx + 32, bpy);
    step(0, 0, 0, 0, bpx, bpy);
    step(0, 0, 0, 0, near(mbx, 64), near(mby, 32));
  endtask

  typedef struct {
    int         sx;
    int         sy;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // blast of a bomb at cell (7,6), first blast frame
    tbl[0]  = '{293, 229, FLAME_IDX0};  // centre (7,6)
    tbl[1]  = '{229, 229, FLAME_IDX0};  // (5,6)
    tbl[2]  = '{357, 229, FLAME_IDX0};  // (9,6)
    tbl[3]  = '{197, 229, 8'd137};      // (4,6) beyond range
    tbl[4]  = '{389, 229, 8'd137};      // (10,6) beyond range
    tbl[5]  = '{293, 165, FLAME_IDX0};  // (7,4)
    tbl[6]  = '{293, 293, FLAME_IDX0};  // (7,8)
    tbl[7]  = '{293, 133, 8'd137};      // (7,3)
    tbl[8]  = '{293, 325, 8'd137};      // (7,9)
    tbl[9]  = '{325, 261, 8'd137};      // (8,7) diagonal
    tbl[10] = '{288, 224, FLAME_IDX0};  // first pixel of (7,6)
    tbl[11] = '{325, 197, 8'd137};      // (8,5) diagonal

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_color", flame_color, 137);
    chk("reset_busy", busy, 0);
    chk("reset_expl", exploding, 0);
    @(negedge clk) reset_n = 1'b1;

    // coarse scan of an idle frame
    for (int y = 0; y < 525; y += 35)
      for (int x = 0; x < 800; x += 29)
        step(0, 0, 0, 0, x, y);

    // out-of-grid drops are ignored
    step(0, 1, 15, 3, 100, 100);
    step(0, 1, 3, 13, 100, 100);
    chk("oob_drop_busy", busy, 0);

    // bomb at (7,6): blink, 120-frame fuse, blast cross, 30-frame blast
    step(0, 1, 7, 6, 293, 229);
    for (int f = 1; f <= 120; f++) begin
      run_frame();
      if (f == 119) chk("expl_before_120", exploding, 0);
      if (f == 120) chk("expl_at_120", exploding, 1);
    end
    foreach (tbl[i]) begin
      step(0, 0, 0, 0, tbl[i].sx, tbl[i].sy);
      chk("tbl_vec", flame_color, tbl[i].exp);
    end
    for (int f = 1; f <= 30; f++) run_frame();
    chk("idle_after_blast", busy, 0);

    // corner bomb at (0,0): clipped arms, no wrap left/above grid
    step(0, 1, 0, 0, 69, 37);
    for (int f = 1; f <= 120; f++) run_frame();
    step(0, 0, 0, 0, 69, 37);
    chk("corner_centre", flame_color, FLAME_IDX0);
    step(0, 0, 0, 0, 133, 37);
    step(0, 0, 0, 0, 165, 37);
    step(0, 0, 0, 0, 69, 101);
    step(0, 0, 0, 0, 69, 133);
    step(0, 0, 0, 0, 101, 69);
    step(0, 0, 0, 0, 63, 37);
    chk("left_of_grid", flame_color, 137);
    step(0, 0, 0, 0, 10, 37);
    step(0, 0, 0, 0, 69, 31);
    step(0, 0, 0, 0, 1000, 37);
    for (int f = 1; f <= 30; f++) run_frame();

    // second drop during ARMED is ignored; then reset mid-blast
    step(0, 1, 3, 3, 0, 0);
    for (int f = 1; f <= 5; f++) run_frame();
    step(0, 1, 10, 10, 0, 0);
    for (int f = 6; f <= 120; f++) run_frame();
    step(0, 0, 0, 0, 64 + 10 * 32 + 5, 32 + 10 * 32 + 5);
    chk("ignored_drop_cell", flame_color, 137);
    for (int f = 1; f <= 9; f++) run_frame();
    @(negedge clk);
    spotX = 10'(64 + 3 * 32 + 5); spotY = 10'(32 + 3 * 32 + 5);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_color", flame_color, 137);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_expl", exploding, 0);
    fuse_left = 0; blast_left = 0; blast_seen = 0;
    @(negedge clk) reset_n = 1'b1;
    step(0, 0, 0, 0, 64 + 3 * 32 + 5, 32 + 3 * 32 + 5);

    // drop coincident with new_frame in IDLE: that pulse does not count
    step(1, 1, 2, 11, 0, 0);
    for (int f = 1; f <= 120; f++) begin
      step(1, 0, 0, 0, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      if (f == 119) chk("coinc_before_120", exploding, 0);
      if (f == 120) chk("coinc_at_120", exploding, 1);
      step(0, 0, 0, 0, 64 + 2 * 32 + 9, 32 + 11 * 32 + 9);
    end
    for (int f = 1; f <= 30; f++) run_frame();
    chk("coinc_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
